// File: rtl/crossbar_slave_mem.sv
// Word-addressed register-file memory terminating one crossbar slave port.
// Each request is captured, held for LATENCY wait cycles, then completed with
// a single-cycle ack carrying read data. Wrapping read/write counters are kept
// for observability.
module crossbar_slave_mem #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slave_req,
  input  logic        slave_cmd,
  input  logic [31:0] slave_addr,
  input  logic [31:0] slave_wdata,
  output logic [31:0] slave_rdata,
  output logic        slave_ack,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned WCNT_W = $clog2(16);

  // The wait counter is only WCNT_W bits wide, so larger latencies cannot be honoured.
  if (LATENCY > 15) begin : g_bad_latency
    initial $error("crossbar_slave_mem: LATENCY=%0d exceeds 15", LATENCY);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                cap_cmd;
  logic [30:2]         cap_addr;
  logic [31:0]         cap_wdata;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   cap_idx;
  logic                cap_oor;

  // Bit 31 selects this slave in the crossbar and bits [1:0] are the byte
  // offset; neither takes part in word addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_addr[31], slave_addr[1:0]};

  assign cap_idx = cap_addr[ADDR_W+1:2];
  assign cap_oor = |cap_addr[30:ADDR_W+2];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: capture in IDLE, count down in WAIT, one-cycle ACK.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (slave_req) state_nxt = S_WAIT;
      S_WAIT: if (wait_cnt == '0) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request capture, wait countdown, memory access and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slave_ack   <= 1'b0;
      err         <= 1'b0;
      slave_rdata <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      wait_cnt    <= '0;
      cap_cmd     <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (slave_req) begin
            cap_cmd   <= slave_cmd;
            cap_addr  <= slave_addr[30:2];
            cap_wdata <= slave_wdata;
            wait_cnt  <= WCNT_W'(LATENCY);
          end
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            slave_ack <= 1'b1;
            err       <= cap_oor;
            if (cap_cmd) begin
              wr_cnt      <= wr_cnt + 16'd1;
              slave_rdata <= '0;
              if (!cap_oor) mem[cap_idx] <= cap_wdata;
            end else begin
              rd_cnt      <= rd_cnt + 16'd1;
              slave_rdata <= cap_oor ? ERR_DATA : mem[cap_idx];
            end
          end
        end
        S_ACK: begin
          slave_ack   <= 1'b0;
          err         <= 1'b0;
          slave_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_slave_mem.sv
// Self-checking bench for crossbar_slave_mem: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_crossbar_slave_mem;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, cmd;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, err;
  logic [15:0] rd_cnt, wr_cnt;

  logic        req_z, cmd_z;
  logic [31:0] addr_z, wdata_z;
  logic [31:0] rdata_z;
  logic        ack_z, err_z;
  logic [15:0] rd_cnt_z, wr_cnt_z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crossbar_slave_mem #(
    .ADDR_W(4), .LATENCY(LAT), .RESET_VAL(32'h0000_0000), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slave_req(req), .slave_cmd(cmd),
    .slave_addr(addr), .slave_wdata(wdata), .slave_rdata(rdata),
    .slave_ack(ack), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  crossbar_slave_mem #(
    .ADDR_W(4), .LATENCY(0), .RESET_VAL(32'h0000_0000), .ERR_DATA(32'hDEAD_BEEF)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .slave_req(req_z), .slave_cmd(cmd_z),
    .slave_addr(addr_z), .slave_wdata(wdata_z), .slave_rdata(rdata_z),
    .slave_ack(ack_z), .err(err_z), .rd_cnt(rd_cnt_z), .wr_cnt(wr_cnt_z)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [16];
  int          m_rd, m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
    m_rd = 0;
    m_wr = 0;
  endtask

  // Word number ignores bit 31; only words 0..15 exist.
  task automatic model_access(input logic c, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] r, output logic e);
    int unsigned word;
    word = (a & 32'h7FFF_FFFF) / 4;
    e = (word >= 16);
    r = 32'h0;
    if (!c) begin
      m_rd = (m_rd + 1) % 65536;
      r = e ? 32'hDEAD_BEEF : m_mem[word];
    end else begin
      m_wr = (m_wr + 1) % 65536;
      if (!e) m_mem[word] = d;
    end
  endtask

  // One full transaction on the LATENCY=2 instance; optionally drops req and
  // scrambles inputs during the wait phase.
  task automatic do_txn(input logic c, input logic [31:0] a, input logic [31:0] d,
                        input bit drop, output logic [31:0] r, output logic e);
    int          n;
    logic [31:0] er;
    logic        ee;
    cmd = c; addr = a; wdata = d; req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop && n == 1) begin
        req = 1'b0; cmd = ~c; addr = $urandom; wdata = $urandom;
      end
    end while (!ack && n < 40);
    r = rdata;
    e = err;
    if (!ack) begin
      chk("ack_timeout", ack, 1'b1);
      req = 1'b0;
      return;
    end
    chk("ack_latency", n, LAT + 2);
    model_access(c, a, d, er, ee);
    chk("rdata", rdata, er);
    chk("err", err, ee);
    chk("rd_cnt", rd_cnt, m_rd);
    chk("wr_cnt", wr_cnt, m_wr);
    req = 1'b0;
    @(negedge clk);
    chk("ack_pulse", ack, 1'b0);
    chk("err_clear", err, 1'b0);
    chk("rdata_clear", rdata, 32'h0);
  endtask

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] r, er, a;
    logic        e, ee;
    int          n, t_prev, t_now, acks;

    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er, a;
    logic        e, ee;
    int          n, t_prev, t_now, acks;

    vecs[0]  = '{1'b0, 32'h0000_000C, 32'h0,          32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h8000_0008, 32'h000F_EED1,  32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h8000_0008, 32'h0,          32'h000F_EED1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,          32'h000F_EED1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0100, 32'h1234_5678,  32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_003F, 32'hA5A5_A5A5,  32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_003C, 32'h0,          32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b0, 32'h4000_003C, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[10] = '{1'b1, 32'h8000_0040, 32'h7777_7777,  32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    req = 1'b0; cmd = 1'b0; addr = '0; wdata = '0;
    req_z = 1'b0; cmd_z = 1'b0; addr_z = '0; wdata_z = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 16'h0);
    chk("rst_wr_cnt", wr_cnt, 16'h0);
    chk("rst_ack_z", ack_z, 1'b0);
    chk("rst_wr_cnt_z", wr_cnt_z, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, 1'b0, r, e);
      chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end

    // Every word still matches the model after the out-of-range writes.
    for (int w = 0; w < 16; w++) begin
      do_txn(1'b0, 32'(w * 4), 32'h0, 1'b0, r, e);
    end

    // req held high across three reads; addr changes only after each ack.
    req = 1'b1; cmd = 1'b0; addr = 32'h0000_0004; t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack && n < 40);
      if (!ack) begin
        chk("b2b_timeout", ack, 1'b1);
        break;
      end
      t_now = cyc;
      if (k > 0) chk("b2b_spacing", t_now - t_prev, LAT + 3);
      model_access(1'b0, addr, 32'h0, er, ee);
      chk("b2b_rdata", rdata, er);
      chk("b2b_rd_cnt", rd_cnt, m_rd);
      t_prev = t_now;
      addr = 32'h0000_0004 + 32'(4 * (k + 1));
      if (k == 2) req = 1'b0;
    end
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("b2b_no_extra_ack", acks, 0);
    chk("b2b_final_rd_cnt", rd_cnt, m_rd);

    // Randomized traffic, occasionally dropping req during the wait phase.
    for (int t = 0; t < 80; t++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[30:6] = '0;
      repeat ($urandom_range(2)) @(negedge clk);
      do_txn(1'(($urandom_range(1))), a, $urandom, ($urandom_range(7) == 0), r, e);
    end

    // Reset while a write sits in WAIT: aborted, nothing committed.
    cmd = 1'b1; addr = 32'h0000_0014; wdata = 32'h5555_AAAA; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_rd_cnt", rd_cnt, 16'h0);
    chk("abort_wr_cnt", wr_cnt, 16'h0);
    do_txn(1'b0, 32'h0000_0014, 32'h0, 1'b0, r, e);
    chk("abort_word", r, 32'h0);
    do_txn(1'b1, 32'h0000_0014, 32'hC0DE_0001, 1'b0, r, e);
    do_txn(1'b0, 32'h0000_0014, 32'h0, 1'b0, r, e);
    chk("post_abort_read", r, 32'hC0DE_0001);

    // LATENCY=0 instance: preset wr_cnt to all-ones, then one write wraps it.
    force dut0.wr_cnt = 16'hFFFF;
    @(negedge clk);
    release dut0.wr_cnt;
    @(negedge clk);
    chk("z_preset", wr_cnt_z, 16'hFFFF);
    cmd_z = 1'b1; addr_z = 32'h0000_0010; wdata_z = 32'hBEEF_0004; req_z = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_z && n < 40);
    chk("z_ack_seen", ack_z, 1'b1);
    chk("z_latency", n, 2);
    chk("z_wrap", wr_cnt_z, 16'h0000);
    chk("z_err", err_z, 1'b0);
    req_z = 1'b0;
    @(negedge clk);
    chk("z_ack_pulse", ack_z, 1'b0);
    cmd_z = 1'b0; req_z = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_z && n < 40);
    chk("z_rd_latency", n, 2);
    chk("z_rdata", rdata_z, 32'hBEEF_0004);
    chk("z_rd_cnt", rd_cnt_z, 16'h1);
    req_z = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossbar_slave_mem.md
Name: crossbar_slave_mem

Overview:
- Word-addressed register-file memory that terminates one slave port of crossbar_top (slave_N_*), i.e. the stage directly downstream of the crossbar.
- Accepts one read or write per request, inserts a fixed number of wait states, and returns a one-cycle ack with read data.
- Replaces the hand-driven ack_s*/rdata_s* stimulus at system level.
- Keeps wrapping read/write transaction counters for observability.

Parameters:
- ADDR_W, 4: word-index width; memory depth 2**ADDR_W 32-bit words.
- LATENCY, 2: wait cycles between request capture and ack (0..15).
- RESET_VAL, 32'h0000_0000: value loaded into every word on reset.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned for an out-of-range read.

Ports:
- clk, input, 1: clock, all logic on posedge.
- rst_n, input, 1: synchronous active-low reset.
- slave_req, input, 1: request from crossbar, held until ack.
- slave_cmd, input, 1: 0 = read, 1 = write.
- slave_addr, input, 32: byte address. Bit 31 is the crossbar slave-select bit and is ignored here. Bits [ADDR_W+1:2] are the word index.
- slave_wdata, input, 32: write data.
- slave_rdata, output, 32: read data, valid only while slave_ack = 1.
- slave_ack, output, 1: one-cycle completion pulse.
- err, output, 1: pulses together with slave_ack when the access was out of range.
- rd_cnt, output, 16: completed reads, wraps at 16'hFFFF -> 0.
- wr_cnt, output, 16: completed writes, wraps.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n = 0 at a posedge):
  - state = IDLE; slave_ack = 0; err = 0; slave_rdata = 0.
  - rd_cnt = 0; wr_cnt = 0; wait counter = 0.
  - All memory words = RESET_VAL.
- Every output is registered. Reset asserted mid-transaction aborts it: no ack, no write, no counter update.
- State IDLE:
  - If slave_req = 1 at edge N, capture cmd, addr and wdata, then go to WAIT with counter = LATENCY.
  - Inputs are ignored from capture until ack; the captured copy is used.
- State WAIT:
  - While counter != 0, decrement each edge.
  - When counter == 0, go to ACK at that edge and perform the access.
  - Resulting timing: slave_ack is high during the cycle following edge N+1+LATENCY. LATENCY = 0 gives ack high after edge N+1; the default 2 gives ack after edge N+3.
- The access, performed on the WAIT->ACK edge:
  - Out of range means captured addr[30:ADDR_W+2] != 0.
  - Read, in range: slave_rdata <= mem[index].
  - Read, out of range: slave_rdata <= ERR_DATA, err <= 1.
  - Write, in range: mem[index] <= wdata, slave_rdata <= 0.
  - Write, out of range: memory untouched, err <= 1, slave_rdata <= 0.
  - rd_cnt or wr_cnt increments by 1 on this edge, out-of-range accesses included.
- State ACK:
  - Lasts exactly one cycle; the next edge returns to IDLE and clears slave_ack, err and slave_rdata.
  - slave_req sampled at the ACK->IDLE edge belongs to the finishing transaction and is not captured.
- Back-to-back: a new request is captured no earlier than the first edge after returning to IDLE. The minimum request-to-request spacing is LATENCY+3 cycles.
- Read-after-write to the same word returns the newly written data.
- slave_req dropping during WAIT (protocol violation): the transaction still completes and acks. No abort.
- Counter width is $clog2(16) bits. LATENCY > 15 is a parameter error and the RTL must check it with an initial $error.

Test Plan:
1. Reset, then read word 3 with LATENCY = 2: req high at edge 0 -> ack high for exactly one cycle after edge 3, rdata = 32'h0, err = 0, rd_cnt = 1.
2. Write addr 32'h8000_0008 with wdata 32'h000F_EED1, then read the same address -> second ack returns rdata = 32'h000F_EED1; bit 31 ignored; wr_cnt = 1, rd_cnt = 1.
3. Read addr 32'h0000_0100 (ADDR_W = 4, out of range) -> ack with err = 1, rdata = 32'hDEAD_BEEF. A following write to 32'h0000_0100 -> err = 1 and all 16 words unchanged.
4. req held high continuously for 3 transactions, master changing addr only after ack -> 3 acks exactly LATENCY+3 = 5 cycles apart; no extra capture at the ack edge.
5. rst_n driven low while in WAIT after a write request -> no ack; written word keeps RESET_VAL; counters = 0; next request after reset completes normally.
6. LATENCY = 0 build, then preload wr_cnt to 16'hFFFF by 65535 writes or a force -> ack one cycle after capture; the next write wraps wr_cnt to 16'h0000.
